// File: rtl/arbiter_pkg.sv
// Shared types and constants for the four-requester arbiter and its priority picker.
package arbiter_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_REL   = 2'd2
    } state_e;

    // Registered output bundle presented to the clients and the resource mux.
    typedef struct packed {
        logic [N_REQ-1:0] grant;
        logic [IDX_W-1:0] idx;
        logic             busy;
        logic             timeout;
    } arb_out_t;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/arbiter_x4_if.sv
// Request/grant bundle between the four clients (master) and the arbiter (slave).
interface arbiter_x4_if;
    import arbiter_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             busy;
    logic             timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, busy, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, busy, timeout
    );

endinterface

// File: rtl/prio_pick_x4.sv
// Combinational 4-input priority picker: scans upward from start with wrap,
// first set request wins.
module prio_pick_x4
    import arbiter_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] pos;

    // Walk from the far end back toward start so the nearest set bit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = start + IDX_W'(k);
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbiter_x4.sv
// Four-requester arbiter: registered one-hot grant, hold-until-done ownership,
// hold timeout and a one-cycle release gap. Define ROUND_ROBIN_EN for rotating priority.
module arbiter_x4
    import arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 15,
    parameter int unsigned CNT_W    = 4
) (
    input  logic         clk,
    input  logic         reset,
    arbiter_x4_if.slave  bus
);

    localparam logic [CNT_W-1:0] MAX_HOLD_C = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    arb_out_t         out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] pick_req;
    logic [IDX_W-1:0] pick_start;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [IDX_W-1:0] win_idx;

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    assign pick_req   = bus.req;
    assign pick_start = ptr_q;
    assign win_idx    = pick_idx;
`else
    // Bit-reversing the request makes the upward scan from 0 select the highest set bit.
    assign pick_req   = {bus.req[0], bus.req[1], bus.req[2], bus.req[3]};
    assign pick_start = '0;
    assign win_idx    = ~pick_idx;
`endif

    prio_pick_x4 u_pick (
        .req   (pick_req),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    logic hold_hit;
    logic req_lost;

    assign hold_hit = (MAX_HOLD != 0) && (cnt_q == MAX_HOLD_C);
    assign req_lost = ~bus.req[out_q.idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
`ifdef ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next state; timeout defaults low so it only pulses for the REL cycle.
    always_comb begin
        state_d       = state_q;
        out_d         = out_q;
        out_d.timeout = 1'b0;
        cnt_d         = cnt_q;
`ifdef ROUND_ROBIN_EN
        ptr_d         = ptr_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d     = ST_GRANT;
                    out_d.grant = idx_to_onehot(win_idx);
                    out_d.idx   = win_idx;
                    out_d.busy  = 1'b1;
                    cnt_d       = CNT_W'(1);
`ifdef ROUND_ROBIN_EN
                    ptr_d       = win_idx + IDX_W'(1);
`endif
                end
            end
            ST_GRANT: begin
                if (bus.done || req_lost || hold_hit) begin
                    state_d       = ST_REL;
                    out_d.grant   = '0;
                    out_d.busy    = 1'b0;
                    out_d.timeout = hold_hit && !bus.done && !req_lost;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.grant     = out_q.grant;
    assign bus.grant_idx = out_q.idx;
    assign bus.busy      = out_q.busy;
    assign bus.timeout   = out_q.timeout;

endmodule

// File: tb/tb_arbiter_x4.sv
// Scoreboard bench for arbiter_x4: an ownership-level model predicts each cycle's
// outputs into a queue; a negedge monitor pops and compares.
module tb_arbiter_x4;
    import arbiter_pkg::*;

    localparam int MAX_HOLD = 15;

    logic clk = 1'b0;
    logic reset;

    arbiter_x4_if bus ();

    arbiter_x4 #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    arb_out_t exp_q[$];

    // Model state: current owner (-1 = none), last owner, cycles held, gap cycles left, rr pointer.
    int m_owner = -1;
    int m_last  = 0;
    int m_hold  = 0;
    int m_gap   = 0;
    int m_ptr   = 0;

    function automatic int pick(input logic [3:0] rq, input int ptr);
`ifdef ROUND_ROBIN_EN
        for (int k = 0; k < 4; k++) begin
            if (rq[(ptr + k) % 4]) return (ptr + k) % 4;
        end
`else
        if (ptr < 0) return -1;
        for (int i = 3; i >= 0; i--) begin
            if (rq[i]) return i;
        end
`endif
        return -1;
    endfunction

    task automatic model_edge(input logic r_in, input logic [3:0] rq, input logic d_in);
        arb_out_t e;
        logic     to;
        int       w;
        to = 1'b0;
        if (r_in) begin
            m_owner = -1; m_last = 0; m_hold = 0; m_gap = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            logic timed;
            timed = (MAX_HOLD != 0) && (m_hold == MAX_HOLD);
            if (d_in || !rq[m_owner] || timed) begin
                to      = timed && !d_in && rq[m_owner];
                m_owner = -1;
                m_gap   = 1;
            end else begin
                m_hold++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (rq != 4'b0000) begin
            w       = pick(rq, m_ptr);
            m_owner = w;
            m_last  = w;
            m_hold  = 1;
            m_ptr   = (w + 1) % 4;
        end
        e.grant   = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        e.idx     = 2'(m_last);
        e.busy    = (m_owner >= 0);
        e.timeout = to;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            arb_out_t e;
            e = exp_q.pop_front();
            chk("grant",     32'(bus.grant),     32'(e.grant));
            chk("grant_idx", 32'(bus.grant_idx), 32'(e.idx));
            chk("busy",      32'(bus.busy),      32'(e.busy));
            chk("timeout",   32'(bus.timeout),   32'(e.timeout));
            chk("onehot0",   32'($onehot0(bus.grant)), 32'd1);
        end
    end

    task automatic step(input logic r_in, input logic [3:0] rq, input logic d_in);
        reset    = r_in;
        bus.req  = rq;
        bus.done = d_in;
        @(posedge clk);
        model_edge(r_in, rq, d_in);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        logic [3:0] rq_r;
        reset    = 1'b1;
        bus.req  = 4'b1111;
        bus.done = 1'b0;

        // Reset held with all requests, then first grant.
        step(1'b1, 4'b1111, 1'b0);
        step(1'b1, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        step(1'b0, 4'b1111, 1'b1);
        idle_n(3);

        // Single requesters released by done.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'(1 << i), 1'b0);
            step(1'b0, 4'(1 << i), 1'b0);
            step(1'b0, 4'(1 << i), 1'b1);
            idle_n(2);
        end

        // Priority and no preemption.
        step(1'b0, 4'b0101, 1'b0);
        step(1'b0, 4'b0101, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1101, 1'b0);
        step(1'b0, 4'b1101, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b1101, 1'b0);
        step(1'b0, 4'b1101, 1'b1);
        idle_n(3);

        // Hold timeout and re-grant.
        for (int i = 0; i < 40; i++) step(1'b0, 4'b0010, 1'b0);
        idle_n(3);

        // done coinciding with the last hold cycle.
        step(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 14; i++) step(1'b0, 4'b0010, 1'b0);
        step(1'b0, 4'b0010, 1'b1);
        idle_n(3);

        // Requester drops mid-grant.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b0100, 1'b0);
        idle_n(3);

        // Reset during GRANT.
        step(1'b0, 4'b1000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        step(1'b1, 4'b1000, 1'b0);
        idle_n(2);

        // All requesting, done each grant (owner sequence depends on priority mode).
        for (int i = 0; i < 20; i++) step(1'b0, 4'b1111, bus.busy);
        idle_n(3);

        // Randomised traffic.
        rq_r = 4'b0000;
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) rq_r[b] = ~rq_r[b];
            end
            step(($urandom_range(0, 199) == 0), rq_r, ($urandom_range(0, 7) == 0));
        end

        idle_n(4);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
